// File: rtl/mic_i2s_capture.sv
// mic_i2s_capture: captures one channel of an I2S microphone stream into a sign-extended 32-bit sample
// with a one-cycle read_ready strobe, a sticky frame_error and a running sample count.
module mic_i2s_capture #(
    parameter int DATA_BITS = 24,
    parameter bit CHANNEL   = 1'b0
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        enable,
    input  logic        i2s_sck,
    input  logic        i2s_ws,
    input  logic        i2s_sd,
    output logic [31:0] mic_data,
    output logic        read_ready,
    output logic        frame_error,
    output logic [31:0] sample_count
);
    localparam int CW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, ALIGN, SHIFT} state_t;

    state_t               state_q, state_d;
    logic [2:0]           sck_q, sck_d;
    logic [1:0]           ws_q, ws_d, sd_q, sd_d;
    logic                 ws_prev_q, ws_prev_d;
    logic [DATA_BITS-2:0] sr_q, sr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [31:0]          mic_data_q, mic_data_d, count_q, count_d;
    logic                 read_ready_q, read_ready_d, frame_error_q, frame_error_d;
    logic                 sck_edge, ws_s;
    logic [DATA_BITS-1:0] word;

    always_comb begin
        sck_d         = {sck_q[1:0], i2s_sck};
        ws_d          = {ws_q[0], i2s_ws};
        sd_d          = {sd_q[0], i2s_sd};
        sck_edge      = sck_q[1] & ~sck_q[2];
        ws_s          = ws_q[1];
        word          = {sr_q, sd_q[1]};
        ws_prev_d     = sck_edge ? ws_s : ws_prev_q;
        state_d       = state_q;
        sr_d          = sr_q;
        cnt_d         = cnt_q;
        mic_data_d    = mic_data_q;
        read_ready_d  = 1'b0;
        frame_error_d = frame_error_q;
        count_d       = count_q;
        if (!enable)
            state_d = IDLE;
        else if (state_q == IDLE)
            state_d = ALIGN;
        else if (sck_edge && state_q == ALIGN) begin
            // the bit at the frame-start edge is the I2S delay slot and is dropped
            if (ws_s == CHANNEL && ws_prev_q != CHANNEL) begin
                state_d = SHIFT;
                cnt_d   = '0;
            end
        end else if (sck_edge && state_q == SHIFT) begin
            // WS may already have moved on by the edge of the final bit, so only earlier bits can truncate
            if (ws_s != CHANNEL && cnt_q != LAST) begin
                frame_error_d = 1'b1;
                state_d       = ALIGN;
            end else begin
                sr_d  = word[DATA_BITS-2:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d      = ALIGN;
                    mic_data_d   = 32'($signed(word));
                    read_ready_d = 1'b1;
                    count_d      = count_q + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= IDLE;
            sck_q         <= '0;
            ws_q          <= '0;
            sd_q          <= '0;
            ws_prev_q     <= ~CHANNEL;
            sr_q          <= '0;
            cnt_q         <= '0;
            mic_data_q    <= '0;
            read_ready_q  <= 1'b0;
            frame_error_q <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            sck_q         <= sck_d;
            ws_q          <= ws_d;
            sd_q          <= sd_d;
            ws_prev_q     <= ws_prev_d;
            sr_q          <= sr_d;
            cnt_q         <= cnt_d;
            mic_data_q    <= mic_data_d;
            read_ready_q  <= read_ready_d;
            frame_error_q <= frame_error_d;
            count_q       <= count_d;
        end
    end

    assign mic_data     = mic_data_q;
    assign read_ready   = read_ready_q;
    assign frame_error  = frame_error_q;
    assign sample_count = count_q;
endmodule
